spi_slave_mmio: RTL

SPI target (slave) peripheral, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames. It is the far end of the spi_mmio controller and hangs on the same MMIO bus. External SPI pins are oversampled in the clk domain. Received bytes go into an RX FIFO. Transmit bytes come from a single TX holding register that the CPU loads over MMIO.

---
 rtl/spi_slave_mmio.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_mmio.sv
// spi_slave_mmio: SPI mode-0 target (MSB first, 8-bit frames) with an MMIO register block,
// an RX FIFO and a single TX holding register. SPI pins are oversampled in the clk domain.
module spi_slave_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_2000,
  parameter int unsigned RX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        spi_miso_oe
);
  localparam int unsigned PtrW  = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [4:0]  Depth = 5'(RX_DEPTH);

  // Synchronisers: [1] is the synced value, [2] the edge-detect reference.
  logic [2:0] sclk_sync, cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

  // Registered state and next-state.
  logic            en_q, en_d, tx_empty_q, tx_empty_d, ovf_q, ovf_d, udr_q, udr_d;
  logic            active_q, active_d, miso_q, miso_d, oe_q, oe_d, ready_q, ready_d;
  logic [7:0]      hold_q, hold_d, shift_rx_q, shift_rx_d, shift_tx_q, shift_tx_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic [7:0]      fifo_mem [RX_DEPTH];

  logic        sel, wr, rd, busy, full, push, pop, flush, load, push_ok, fifo_we;
  logic [7:0]  load_val;
  logic [31:0] status;
  logic        unused_wdata;

  assign unused_wdata = ^mem_wdata[31:8];

  // Shift the asynchronous SPI pins through the synchroniser chains.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= 3'b000;
      cs_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_sclk};
      cs_sync   <= {cs_sync[1:0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign mosi_s    = mosi_sync[1];

  assign sel      = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && !ready_q;
  assign wr       = sel && (mem_wmask != 4'b0000);
  assign rd       = sel && (mem_wmask == 4'b0000);
  assign busy     = ~cs_sync[1] & en_q;
  assign full     = (count_q == Depth);
  assign load_val = tx_empty_q ? 8'hFF : hold_q;
  assign status   = {19'b0, count_q, 2'b00, busy, udr_q, ovf_q, tx_empty_q, full,
                     (count_q != 5'd0)};

  // Next-state: bus decode first, then frame engine, so engine set events override W1C.
  always_comb begin
    en_d       = en_q;
    tx_empty_d = tx_empty_q;
    ovf_d      = ovf_q;
    udr_d      = udr_q;
    active_d   = active_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    hold_d     = hold_q;
    shift_rx_d = shift_rx_q;
    shift_tx_d = shift_tx_q;
    bit_cnt_d  = bit_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ready_d    = sel;
    rdata_d    = 32'h0;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    load       = 1'b0;

    if (wr && mem_wmask[0]) begin
      case (mem_addr[3:0])
        4'h0: begin
          en_d  = mem_wdata[0];
          flush = mem_wdata[1];
        end
        4'h4: begin
          if (mem_wdata[3]) ovf_d = 1'b0;
          if (mem_wdata[4]) udr_d = 1'b0;
        end
        4'h8: begin
          // A load in the same cycle sees the old TX_EMPTY, so these never conflict.
          if (tx_empty_q) begin
            hold_d     = mem_wdata[7:0];
            tx_empty_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (rd) begin
      case (mem_addr[3:0])
        4'h0: rdata_d = {31'b0, en_q};
        4'h4: rdata_d = status;
        4'hC: begin
          if (count_q != 5'd0) begin
            rdata_d = {24'b0, fifo_mem[rd_ptr_q]};
            pop     = 1'b1;
          end
        end
        default: rdata_d = 32'h0;
      endcase
    end

    if (!en_q) begin
      // Disabled: drop any frame so re-enabling waits for a fresh cs_n fall.
      active_d = 1'b0;
      miso_d   = 1'b1;
      oe_d     = 1'b0;
    end else if (cs_fall) begin
      active_d  = 1'b1;
      bit_cnt_d = 3'd0;
      load      = 1'b1;
      miso_d    = load_val[7];
      oe_d      = 1'b1;
    end else if (cs_rise) begin
      active_d  = 1'b0;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b1;
      oe_d      = 1'b0;
    end else if (active_q) begin
      if (sclk_rise) begin
        shift_rx_d = {shift_rx_q[6:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          push = 1'b1;
          load = 1'b1;
        end
      end else if (sclk_fall) begin
        if (bit_cnt_q != 3'd0) begin
          shift_tx_d = {shift_tx_q[6:0], 1'b0};
          miso_d     = shift_tx_q[6];
        end else begin
          miso_d = shift_tx_q[7];
        end
      end
    end

    if (load) begin
      shift_tx_d = load_val;
      if (tx_empty_q) udr_d = 1'b1;
      else tx_empty_d = 1'b1;
    end

    // A same-cycle pop frees a slot for the push.
    push_ok = push && (!full || pop);
    if (push && full && !pop && !flush) ovf_d = 1'b1;
    fifo_we = push_ok && !flush;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 5'd0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + 5'(push_ok) - 5'(pop);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q       <= 1'b0;
      tx_empty_q <= 1'b1;
      ovf_q      <= 1'b0;
      udr_q      <= 1'b0;
      active_q   <= 1'b0;
      miso_q     <= 1'b1;
      oe_q       <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'h0;
      hold_q     <= 8'h00;
      shift_rx_q <= 8'h00;
      shift_tx_q <= 8'h00;
      bit_cnt_q  <= 3'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
    end else begin
      en_q       <= en_d;
      tx_empty_q <= tx_empty_d;
      ovf_q      <= ovf_d;
      udr_q      <= udr_d;
      active_q   <= active_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      hold_q     <= hold_d;
      shift_rx_q <= shift_rx_d;
      shift_tx_q <= shift_tx_d;
      bit_cnt_q  <= bit_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (fifo_we) fifo_mem[wr_ptr_q] <= shift_rx_d;
  end

  assign mem_ready   = ready_q;
  assign mem_rdata   = rdata_q;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
endmodule
